adc_serial_reader: RTL and testbench
====================================

Name: adc_serial_reader

Overview:
- Initiator side of the temperature ADC link.
- Drives a serial 8-bit ADC (chip-select plus serial clock, one data line, ADC0831-style framing) and deserialises each conversion.
- Presents the result on a stable parallel bus that feeds the controller's adc input.
- Conversions start on request or on a programmable auto-sample interval.

Parameters:
DIV, 4, sclk half-period in clk cycles (>=1)
WIDTH, 8, conversion data bits
INTERVAL, 200, clk cycles between automatic conversions; 0 disables auto-sampling

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  permits conversions; gates the auto-interval counter
start  input  1  single-cycle conversion request
adc_dout  input  1  serial data from ADC
adc_cs_n  output  1  ADC chip select, active-low
adc_sclk  output  1  ADC serial clock
adc  output  WIDTH  last good conversion, held stable between updates
valid  output  1  one-cycle pulse when adc updates
busy  output  1  frame or recovery in progress
frame_err  output  1  last completed frame had a bad null bit

Behaviour:
- Reset (reset=0, asynchronous, any state): state=IDLE, adc_cs_n=1, adc_sclk=0, adc=0, valid=0, busy=0, frame_err=0, all counters=0.
- States: IDLE -> FRAME -> DONE -> RECOVER -> IDLE.
- Interval counter:
  - Increments every cycle while enable=1 and saturates at INTERVAL-1.
  - Clears on every frame start.
  - Held at 0 while enable=0.
- Trigger, evaluated only in IDLE with enable=1: start=1 OR (INTERVAL!=0 AND counter==INTERVAL-1).
  - Simultaneous start and auto trigger give one conversion.
  - start outside IDLE is ignored, not queued.
- Frame timing, trigger sampled in cycle T:
  - T+1: adc_cs_n=0, busy=1, adc_sclk=0.
  - adc_sclk toggles every DIV cycles.
  - Rising edge k (k=1..WIDTH+2) at T+1+(2k-1)*DIV.
  - adc_dout is sampled in the clk cycle in which adc_sclk is driven high.
- Frame contents:
  - Edge 1: mux settle, data ignored.
  - Edge 2: null bit, expected 0.
  - Edges 3..WIDTH+2: data, MSB first, into the shift register.
- DONE at cycle T+1+2*(WIDTH+2)*DIV (T+81 at defaults):
  - adc_cs_n=1, adc_sclk=0.
  - Null bit 0: adc<=shift register, valid=1 for exactly this cycle, frame_err<=0.
  - Null bit 1: adc unchanged, valid stays 0, frame_err<=1.
- RECOVER: adc_cs_n held high for DIV cycles, busy=1. busy falls to 0 at DONE+DIV+1 (T+86 at defaults); IDLE accepts a trigger from that cycle.
- enable falling mid-frame: the frame completes normally; no new trigger is taken.
- adc changes only in DONE of a good frame. frame_err is sticky until the next good frame.
- reset asserted mid-frame: immediate return to reset values; adc_cs_n goes high asynchronously; the partial frame is discarded.

Test Plan:
1. Reset: reset=0 with random inputs -> adc_cs_n=1, adc_sclk=0, adc=0x00, valid=0, busy=0, frame_err=0.
2. start pulse at T, ADC model sends null=0, data 0xA5 -> adc_cs_n low at T+1; exactly 10 sclk rising edges, period 8 clk; valid high only at T+81 with adc=0xA5; busy low at T+86.
3. INTERVAL=200, enable=1, start=0 -> frames start every 200 cycles; 3 consecutive conversions return model values 0x10, 0x20, 0x30; enable=0 -> no further frames and counter held at 0.
4. Model drives null bit 1 with data 0xFF -> no valid pulse, adc stays 0xA5, frame_err=1; next good frame with 0x3C -> valid, adc=0x3C, frame_err=0.
5. start held high during a frame -> no second frame until IDLE. Auto trigger and start in the same cycle -> exactly one frame.
6. reset=0 at edge 5 of a frame -> adc_cs_n=1 and adc=0 immediately. After release, start with 0x7E -> complete frame, adc=0x7E, frame_err=0.

Source files
------------

// File: rtl/adc_serial_reader.sv
// Initiator for an ADC0831-style serial ADC: frames one conversion per trigger
// (start pulse or auto interval) and holds the last good result on a parallel bus.
module adc_serial_reader #(
  parameter int DIV      = 4,
  parameter int WIDTH    = 8,
  parameter int INTERVAL = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             adc_dout,
  output logic             adc_cs_n,
  output logic             adc_sclk,
  output logic [WIDTH-1:0] adc,
  output logic             valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int DW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HALVES = 2 * (WIDTH + 2);
  localparam int HW     = $clog2(HALVES);
  localparam int IW     = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALVES - 1);
  localparam logic [IW-1:0] IVAL_LAST = IW'((INTERVAL > 0) ? INTERVAL - 1 : 0);
  localparam bit            AUTO      = (INTERVAL > 0);

  typedef enum logic [1:0] {IDLE, FRAME, DONE, RECOVER} state_e;

  state_e           state_q;
  logic [DW-1:0]    div_q;
  logic [HW-1:0]    half_q;
  logic [IW-1:0]    ival_q, ival_d;
  logic [WIDTH-1:0] shift_q, adc_q;
  logic             null_q, cs_n_q, sclk_q, valid_q, busy_q, err_q;
  logic             trig;

  assign trig = (state_q == IDLE) && enable && (start || (AUTO && (ival_q == IVAL_LAST)));

  // Interval counter: saturating, cleared on frame start, parked at 0 while disabled.
  always_comb begin
    ival_d = ival_q;
    if (!enable || trig)                   ival_d = '0;
    else if (AUTO && ival_q != IVAL_LAST)  ival_d = ival_q + IW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      half_q  <= '0;
      ival_q  <= '0;
      shift_q <= '0;
      adc_q   <= '0;
      null_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ival_q  <= ival_d;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (trig) begin
          state_q <= FRAME;
          cs_n_q  <= 1'b0;
          sclk_q  <= 1'b0;
          busy_q  <= 1'b1;
          div_q   <= '0;
          half_q  <= '0;
        end
        FRAME: if (div_q == DIV_LAST) begin
          div_q <= '0;
          if (half_q == HALF_LAST) begin
            state_q <= DONE;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            if (null_q) err_q <= 1'b1;
            else begin
              adc_q   <= shift_q;
              valid_q <= 1'b1;
              err_q   <= 1'b0;
            end
          end else begin
            half_q <= half_q + HW'(1);
            sclk_q <= ~sclk_q;
            // Sample on the rising half: edge 1 is mux settle, edge 2 the null bit.
            if (!sclk_q) begin
              if (half_q == HW'(2))       null_q  <= adc_dout;
              else if (half_q >= HW'(4))  shift_q <= {shift_q[WIDTH-2:0], adc_dout};
            end
          end
        end else begin
          div_q <= div_q + DW'(1);
        end
        DONE: begin
          state_q <= RECOVER;
          div_q   <= '0;
        end
        RECOVER: if (div_q == DIV_LAST) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else begin
          div_q <= div_q + DW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign adc_cs_n  = cs_n_q;
  assign adc_sclk  = sclk_q;
  assign adc       = adc_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed bench for adc_serial_reader with a behavioural ADC0831 model.
module tb_adc_serial_reader;
  localparam int DIV = 4, WIDTH = 8, INTERVAL = 200;
  localparam int RISE1  = 1 + DIV;
  localparam int RISEN  = 1 + (2 * (WIDTH + 2) - 1) * DIV;
  localparam int DONE_T = 1 + 2 * (WIDTH + 2) * DIV;
  localparam int BUSY_T = DONE_T + DIV + 1;

  logic clk = 1'b0, reset = 1'b0, enable = 1'b0, start = 1'b0, adc_dout = 1'b0;
  logic adc_cs_n, adc_sclk, valid, busy, frame_err;
  logic [WIDTH-1:0] adc;
  int tests = 0, fails = 0, cyc = 0;

  logic             model_null = 1'b0;
  logic [WIDTH-1:0] model_data = '0;
  int               fall_cnt = 0;
  logic             m_prev_sclk = 1'b0;

  adc_serial_reader #(.DIV(DIV), .WIDTH(WIDTH), .INTERVAL(INTERVAL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .adc_dout(adc_dout),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc(adc), .valid(valid),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic mbit(input int i);
    if (i == 0) return 1'b1;
    if (i == 1) return model_null;
    if (i < WIDTH + 2) return model_data[WIDTH + 1 - i];
    return 1'b0;
  endfunction

  // ADC shifts out the next bit after each falling sclk while selected.
  always @(negedge clk) begin
    if (adc_cs_n) fall_cnt = 0;
    else if (m_prev_sclk && !adc_sclk) fall_cnt++;
    m_prev_sclk = adc_sclk;
    adc_dout = mbit(fall_cnt);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  int r_falls, r_cs_first, r_rises, r_rise_first, r_rise_last, r_vcnt, r_vat, r_busy_fall;
  logic [WIDTH-1:0] r_vadc;

  task automatic frame_run(input logic nb, input logic [WIDTH-1:0] d, input bit hold);
    int t0, rel;
    logic pcs, psclk;
    bit done;
    model_null = nb; model_data = d;
    r_falls = 0; r_cs_first = -1; r_rises = 0; r_rise_first = -1; r_rise_last = -1;
    r_vcnt = 0; r_vat = -1; r_busy_fall = -1; r_vadc = '0;
    pcs = 1'b1; psclk = 1'b0; done = 0;
    @(negedge clk); start = 1'b1; t0 = cyc;
    for (int n = 1; n < 200; n++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (n == 1 && !hold) start = 1'b0;
      if (!adc_cs_n && pcs) begin r_falls++; if (r_cs_first < 0) r_cs_first = rel; end
      if (adc_sclk && !psclk) begin
        r_rises++; r_rise_last = rel;
        if (r_rise_first < 0) r_rise_first = rel;
      end
      if (valid) begin r_vcnt++; r_vat = rel; r_vadc = adc; end
      pcs = adc_cs_n; psclk = adc_sclk;
      if (!busy && rel > 1) begin r_busy_fall = rel; done = 1; break; end
    end
    start = 1'b0;
    chk("frame_end_in_time", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic             nb;
    logic [WIDTH-1:0] data;
    int               exp_v;
    logic [WIDTH-1:0] exp_adc;
    logic             exp_err;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int e0, fidx, nf, rises;
    int fall_at[3];
    logic [WIDTH-1:0] vals[3];
    logic pcs, psclk;
    bit done;

    vecs[0] = '{1'b1, 8'hFF, 0, 8'hA5, 1'b1};
    vecs[1] = '{1'b0, 8'h3C, 1, 8'h3C, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 0, 8'h3C, 1'b1};
    vecs[3] = '{1'b1, 8'h55, 0, 8'h3C, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 8'hFF, 1, 8'hFF, 1'b0};

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      enable = 1'($urandom); start = 1'($urandom);
      chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
      chk("rst_sclk", 32'(adc_sclk), 32'd0);
      chk("rst_adc", 32'(adc), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(frame_err), 32'd0);
    end
    @(negedge clk); enable = 1'b0; start = 1'b0; reset = 1'b1;
    @(negedge clk); enable = 1'b1;

    // Basic frame timing
    frame_run(1'b0, 8'hA5, 0);
    chk("t2_cs_first", r_cs_first, 1);
    chk("t2_rises", r_rises, WIDTH + 2);
    chk("t2_rise_first", r_rise_first, RISE1);
    chk("t2_rise_last", r_rise_last, RISEN);
    chk("t2_vcnt", r_vcnt, 1);
    chk("t2_vat", r_vat, DONE_T);
    chk("t2_vadc", 32'(r_vadc), 32'hA5);
    chk("t2_busy_fall", r_busy_fall, BUSY_T);
    chk("t2_err", 32'(frame_err), 32'd0);

    // Table of good/bad frames
    for (int i = 0; i < 6; i++) begin
      frame_run(vecs[i].nb, vecs[i].data, 0);
      chk($sformatf("vec%0d_vcnt", i), r_vcnt, vecs[i].exp_v);
      chk($sformatf("vec%0d_adc", i), 32'(adc), 32'(vecs[i].exp_adc));
      chk($sformatf("vec%0d_err", i), 32'(frame_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_rises", i), r_rises, WIDTH + 2);
    end

    // start held through a whole frame
    frame_run(1'b0, 8'h5A, 1);
    chk("hold_falls", r_falls, 1);
    chk("hold_rises", r_rises, WIDTH + 2);
    chk("hold_adc", 32'(adc), 32'h5A);
    chk("hold_busy_fall", r_busy_fall, BUSY_T);

    // Auto-sampling, three conversions
    enable = 1'b0; repeat (2) @(negedge clk);
    model_null = 1'b0; model_data = 8'h10;
    fall_at = '{-1, -1, -1}; vals = '{8'h0, 8'h0, 8'h0};
    enable = 1'b1; e0 = cyc; fidx = 0; pcs = 1'b1; done = 0;
    for (int n = 0; n < 900; n++) begin
      @(negedge clk);
      if (!adc_cs_n && pcs && fidx < 3) fall_at[fidx] = cyc - e0;
      if (valid && fidx < 3) begin vals[fidx] = adc; fidx++; model_data = model_data + 8'h10; end
      pcs = adc_cs_n;
      if (fidx == 3 && !busy) begin done = 1; break; end
    end
    enable = 1'b0;
    chk("auto_done", 32'(done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("auto%0d_start", i), fall_at[i], 200 * (i + 1));
      chk($sformatf("auto%0d_adc", i), 32'(vals[i]), 32'h10 * (i + 1));
    end

    // Disabled: no frames
    nf = 0; pcs = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!adc_cs_n && pcs) nf++;
      pcs = adc_cs_n;
    end
    chk("disabled_frames", nf, 0);

    // Re-enable: counter must have been parked at 0
    model_data = 8'h40; enable = 1'b1; e0 = cyc; fidx = -1; pcs = 1'b1; done = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!adc_cs_n && pcs && fidx < 0) fidx = cyc - e0;
      pcs = adc_cs_n;
      if (fidx > 0 && !busy) begin done = 1; break; end
    end
    enable = 1'b0;
    chk("reenable_done", 32'(done), 32'd1);
    chk("reenable_start", fidx, 200);
    chk("reenable_adc", 32'(adc), 32'h40);

    // start coincident with auto trigger; enable drops mid-frame
    repeat (2) @(negedge clk);
    model_data = 8'h66; enable = 1'b1; e0 = cyc; nf = 0; fidx = -1; r_vcnt = 0; pcs = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!adc_cs_n && pcs) begin nf++; if (fidx < 0) fidx = cyc - e0; end
      if (valid) r_vcnt++;
      pcs = adc_cs_n;
      start = (cyc - e0 == 199);
      if (fidx > 0 && cyc - e0 == fidx + 10) enable = 1'b0;
    end
    chk("coinc_frames", nf, 1);
    chk("coinc_start", fidx, 200);
    chk("coinc_vcnt", r_vcnt, 1);
    chk("coinc_adc", 32'(adc), 32'h66);

    // Reset at rising edge 5 of a frame
    enable = 1'b1; model_data = 8'h99;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    rises = 0; psclk = 1'b0; done = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (adc_sclk && !psclk) rises++;
      psclk = adc_sclk;
      if (rises == 5) begin done = 1; break; end
    end
    chk("rst_mid_reached_edge5", 32'(done), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_cs_n", 32'(adc_cs_n), 32'd1);
    chk("rst_mid_sclk", 32'(adc_sclk), 32'd0);
    chk("rst_mid_adc", 32'(adc), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk); reset = 1'b1;
    frame_run(1'b0, 8'h7E, 0);
    chk("post_rst_vcnt", r_vcnt, 1);
    chk("post_rst_adc", 32'(adc), 32'h7E);
    chk("post_rst_err", 32'(frame_err), 32'd0);
    chk("post_rst_rises", r_rises, WIDTH + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end
endmodule
